// File: rtl/bin_to_bcd_seq.sv
// Sequential binary to packed-BCD converter (shift-and-add-3).
// One double-dabble iteration per clock, start/busy/done handshake.
module bin_to_bcd_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
);

  localparam int BW = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [BIN_W-1:0] shift_q, shift_d;
  logic [BW-1:0]    work_q, work_d;
  logic [BW-1:0]    adj;
  logic [4:0]       cnt_q, cnt_d;
  logic             acc_q, acc_d;
  logic [BW-1:0]    bcd_q, bcd_d;
  logic             ovf_q, ovf_d;

  always_comb begin
    adj = work_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (work_q[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          shift_d = bin_in;
          work_d  = '0;
          acc_d   = 1'b0;
          cnt_d   = 5'(BIN_W);
          state_d = CONV;
        end
      end
      CONV: begin
        // top digit's carry-out means the value needs more digits
        acc_d   = acc_q | adj[BW-1];
        work_d  = {adj[BW-2:0], shift_q[BIN_W-1]};
        shift_d = {shift_q[BIN_W-2:0], 1'b0};
        cnt_d   = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          bcd_d   = work_d;
          ovf_d   = acc_d;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      work_q  <= '0;
      cnt_q   <= '0;
      acc_q   <= 1'b0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = (state_q == CONV);
  assign done     = (state_q == DONE);
  assign bcd_out  = bcd_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed and sweep checks for bin_to_bcd_seq.
// Two instances: 3 digits (in range) and 2 digits (overflow).
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start3, start2;
  logic [7:0]  bin3, bin2;
  logic        busy3, done3, ovf3;
  logic        busy2, done2, ovf2;
  logic [11:0] bcd3;
  logic [7:0]  bcd2;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .bin_in(bin3),
    .busy(busy3), .done(done3), .bcd_out(bcd3), .overflow(ovf3)
  );

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .bin_in(bin2),
    .busy(busy2), .done(done2), .bcd_out(bcd2), .overflow(ovf2)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] bcd_of(input int v);
    bcd_of = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Called just after the accepting posedge; returns cycles to done.
  task automatic wait_done(input bit sel, output int lat,
                           output int bcyc, output bit both);
    lat  = 0;
    bcyc = 0;
    both = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sel ? done2 : done3) begin
        both = sel ? busy2 : busy3;
        return;
      end
      if (sel ? busy2 : busy3) bcyc++;
      @(posedge clk);
      lat++;
    end
    lat = -1;
  endtask

  task automatic run3(input int v, input string tag);
    int lat, bcyc;
    bit both;
    @(negedge clk);
    start3 = 1'b1;
    bin3   = 8'(v);
    @(posedge clk);
    wait_done(1'b0, lat, bcyc, both);
    start3 = 1'b0;
    chk({tag, ".bcd"}, 32'(bcd3), 32'(bcd_of(v)));
    chk({tag, ".lat"}, 32'(lat), 32'd8);
    chk({tag, ".ovf"}, 32'(ovf3), 32'd0);
  endtask

  task automatic run2(input int v, input logic [7:0] exp_bcd,
                      input logic exp_ovf, input string tag);
    int lat, bcyc;
    bit both;
    @(negedge clk);
    start2 = 1'b1;
    bin2   = 8'(v);
    @(posedge clk);
    wait_done(1'b1, lat, bcyc, both);
    start2 = 1'b0;
    chk({tag, ".bcd"}, 32'(bcd2), 32'(exp_bcd));
    chk({tag, ".ovf"}, 32'(ovf2), 32'(exp_ovf));
    chk({tag, ".lat"}, 32'(lat), 32'd8);
  endtask

  initial begin
    int lat, bcyc, seen;
    bit both;
    rst    = 1'b1;
    start3 = 1'b0;
    start2 = 1'b0;
    bin3   = '0;
    bin2   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.busy", 32'(busy3), 32'd0);
    chk("rst.done", 32'(done3), 32'd0);
    chk("rst.bcd",  32'(bcd3),  32'd0);
    chk("rst.ovf",  32'(ovf3),  32'd0);
    rst = 1'b0;

    // zero with busy/latency bookkeeping
    @(negedge clk);
    start3 = 1'b1;
    bin3   = 8'd0;
    @(posedge clk);
    wait_done(1'b0, lat, bcyc, both);
    start3 = 1'b0;
    chk("zero.bcd",  32'(bcd3), 32'h000);
    chk("zero.ovf",  32'(ovf3), 32'd0);
    chk("zero.lat",  32'(lat),  32'd8);
    chk("zero.busy", 32'(bcyc), 32'd8);
    chk("zero.both", 32'(both), 32'd0);
    @(negedge clk);
    chk("zero.pulse", 32'(done3), 32'd0);
    chk("zero.hold",  32'(bcd3),  32'h000);

    run3(255, "v255");
    chk("v255.const", 32'(bcd3), 32'h255);
    for (int d = 0; d < 3; d++)
      chk("v255.xs3", 32'(bcd3[4*d +: 4] + 4'd3),
          32'(4'(d == 1 ? 5 : (d == 0 ? 5 : 2)) + 4'd3));
    run3(99, "v99");
    chk("v99.const", 32'(bcd3), 32'h099);
    run3(170, "v170");
    chk("v170.const", 32'(bcd3), 32'h170);

    // start held high, bin_in changes during CONV, back-to-back accept
    @(negedge clk);
    start3 = 1'b1;
    bin3   = 8'd200;
    @(posedge clk);
    @(negedge clk);
    bin3 = 8'd7;
    @(posedge clk);
    wait_done(1'b0, lat, bcyc, both);
    chk("b2b.first", 32'(bcd3), 32'h200);
    chk("b2b.lat1",  32'(lat),  32'd7);
    @(posedge clk);
    @(negedge clk);
    chk("b2b.nogap", 32'(busy3), 32'd1);
    start3 = 1'b0;
    @(posedge clk);
    wait_done(1'b0, lat, bcyc, both);
    chk("b2b.second", 32'(bcd3), 32'h007);
    chk("b2b.lat2",   32'(lat),  32'd7);

    // reset mid-conversion
    @(negedge clk);
    start3 = 1'b1;
    bin3   = 8'd123;
    @(posedge clk);
    @(negedge clk);
    start3 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort.busy", 32'(busy3), 32'd0);
    chk("abort.done", 32'(done3), 32'd0);
    chk("abort.bcd",  32'(bcd3),  32'd0);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done3) seen++;
    end
    chk("abort.nodone", 32'(seen), 32'd0);
    run3(45, "v45");
    chk("v45.const", 32'(bcd3), 32'h045);

    // two-digit instance
    run2(100, 8'h00, 1'b1, "d2.v100");
    run2(99,  8'h99, 1'b0, "d2.v99");
    run2(255, 8'h55, 1'b1, "d2.v255");

    for (int v = 0; v < 256; v++) begin
      run3(v, "sweep");
      for (int d = 0; d < 3; d++)
        chk("sweep.digit", 32'(bcd3[4*d +: 4] <= 4'd9), 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Multi-cycle binary-to-packed-BCD converter using shift-and-add-3 (double dabble).
- Sits directly upstream of the BCD-to-Excess-3 converter and supplies its 4-bit BCD digits.
- Start/busy/done handshake; one iteration per clock.
- Result digits are guaranteed 0-9 whenever overflow=0.

Parameters:
- BIN_W, 8, width of binary input; also the conversion latency in cycles (legal 2..16).
- DIGITS, 3, number of BCD output digits (legal 1..5).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  request a conversion; sampled only when idle (IDLE or DONE state).
- bin_in  input  BIN_W  unsigned binary value; captured on the accepting edge only.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse; bcd_out and overflow are valid.
- bcd_out  output  4*DIGITS  packed BCD; digit 0 in bits [3:0].
- overflow  output  1  value exceeded 10^DIGITS-1; bcd_out holds the low DIGITS digits.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, busy=0, done=0, bcd_out=0, overflow=0, internal shift and BCD registers and counter cleared. Reset wins over start. Reset mid-conversion aborts the conversion with no done pulse.
- FSM states are IDLE, CONV and DONE.
- IDLE/DONE + start=1 at edge k:
  - Load bin_in into the shift register; clear the BCD working register and overflow_acc.
  - Set counter=BIN_W, go to CONV, busy=1.
  - bcd_out and overflow keep their old values until the new result.
- CONV, each edge:
  - For every working digit >=5, add 3 (4-bit, no carry out).
  - Then shift {bcd_work, shift_reg} left by 1.
  - A 1 shifted out of the top digit ORs into overflow_acc.
  - Decrement the counter.
  - start is ignored in CONV; bin_in changes have no effect.
- When the counter reaches 0 (edge k+BIN_W):
  - bcd_out <= final working value; overflow <= overflow_acc (including that edge's shift-out).
  - busy=0, done=1, state=DONE.
- DONE, next edge: done=0. With start=1 a new conversion is accepted (back-to-back, no gap); otherwise go to IDLE.
- Latency: done is high in the cycle after edge k+BIN_W, exactly BIN_W cycles after the accepting edge. busy is high for exactly BIN_W cycles. busy and done are never high together.
- Output hold: bcd_out and overflow hold until the next completed conversion or reset.
- Boundary values:
  - bin_in=0 gives all-zero digits.
  - bin_in=2^BIN_W-1 must convert correctly when DIGITS is sufficient.
  - With insufficient DIGITS, the low digits are still correct (truncation) and overflow=1.
- Arithmetic: all adjustments are per-digit 4-bit; no digit of an in-range result ever exceeds 9.

Test Plan:
- Reset then BIN_W=8, DIGITS=3, bin_in=0, start pulse -> done exactly 8 cycles after the start edge; bcd_out=12'h000, overflow=0; busy high 8 cycles.
- bin_in=255 -> bcd_out=12'h255; bin_in=99 -> 12'h099; bin_in=170 -> 12'h170; overflow=0 each time; each digit fed to the Excess-3 stage yields the correct code.
- start held high, bin_in=200, then bin_in changed to 7 during CONV -> single conversion, bcd_out=12'h200. The start sampled during done is accepted and returns 12'h007 after a further 8 cycles, with no idle gap.
- rst asserted 4 cycles into a conversion of 123 -> next cycle busy=0, done=0, bcd_out=0, no done pulse. A subsequent start with 45 -> 12'h045.
- Instance with DIGITS=2, BIN_W=8: bin_in=100 -> bcd_out=8'h00, overflow=1. Then bin_in=99 -> bcd_out=8'h99, overflow=0.
- Exhaustive sweep of 0..255 at DIGITS=3, compared against a divide/modulo model -> zero mismatches, and every done exactly 8 cycles after its start.
